// File: rtl/ahbl_apb_pkg.sv
// Shared types and protocol constants for the AHB-Lite to multi-slave APB3 bridge.
package ahbl_apb_pkg;

    // Bridge sequencer states
    typedef enum logic [2:0] {
        IDLE,
        WLAT,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    // AHB HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // True for the transfer types that carry a real access
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic active;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/apb_slot_mux.sv
// Return-path multiplexer: picks one APB slot's PRDATA/PREADY/PSLVERR by slot index.
// An index with no slave behind it reads as all zeros (never ready, no error).
module apb_slot_mux #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 16,
    parameter int SLOT_BITS  = 4
) (
    input  logic [SLOT_BITS-1:0]             slot,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr,
    output logic [DATA_WIDTH-1:0]            sel_prdata,
    output logic                             sel_pready,
    output logic                             sel_pslverr
);

    // Select the addressed slot's response signals
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (int'(slot) == k) begin
                sel_prdata  = prdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_pready  = pready[k];
                sel_pslverr = pslverr[k];
            end
        end
    end

endmodule

// File: rtl/ahbl_apb_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB3 master bridge. Decodes a slot index from the
// captured address, drives one-hot PSEL, inserts wait states from PREADY and turns
// PSLVERR, unmapped slots and access timeouts into two-cycle AHB ERROR responses.
module ahbl_apb_bridge_mslv
    import ahbl_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 16,
    parameter int SLOT_BITS      = 4,
    parameter int SLOT_LSB       = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             HSEL,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic [2:0]                       HSIZE,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    input  logic                             HREADYIN,
    output logic                             HREADYOUT,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HRESP,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic                             PENABLE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [SLOT_BITS-1:0]    slot_q, slot_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;

    logic                    accept;
    logic [SLOT_BITS-1:0]    addr_slot;
    logic                    addr_mapped;
    logic [DATA_WIDTH-1:0]   sel_prdata;
    logic                    sel_pready;
    logic                    sel_pslverr;

    // HSIZE is part of the AHB-Lite port set; APB3 has no size qualifier to pass it to.
    logic hsize_unused;
    assign hsize_unused = ^HSIZE;

    assign accept      = HSEL && HREADYIN && htrans_active(HTRANS);
    assign addr_slot   = HADDR[SLOT_LSB +: SLOT_BITS];
    assign addr_mapped = (int'(addr_slot) < NUM_SLAVES);

    apb_slot_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_BITS  (SLOT_BITS)
    ) u_slot_mux (
        .slot        (slot_q),
        .prdata      (PRDATA),
        .pready      (PREADY),
        .pslverr     (PSLVERR),
        .sel_prdata  (sel_prdata),
        .sel_pready  (sel_pready),
        .sel_pslverr (sel_pslverr)
    );

    // Next-state and next-output logic; every output is decoded from the next state so it leaves a flop
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        tmo_d    = tmo_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;

        case (state_q)
            IDLE, ERR2: begin
                // The ERR2 completion cycle doubles as the next address phase.
                state_d = IDLE;
                if (accept) begin
                    slot_d   = addr_slot;
                    paddr_d  = HADDR;
                    pwrite_d = HWRITE;
                    if (!addr_mapped) begin
                        state_d = ERR1;
                    end else if (HWRITE) begin
                        state_d = WLAT;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            WLAT: begin
                pwdata_d = HWDATA;
                state_d  = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (sel_pready) begin
                    if (!pwrite_q) begin
                        hrdata_d = sel_prdata;
                    end
                    state_d = sel_pslverr ? ERR1 : IDLE;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    state_d = ERR1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == SETUP) begin
            tmo_d = '0;
        end

        hreadyout_d = 1'b1;
        hresp_d     = HRESP_OKAY;
        psel_d      = '0;
        penable_d   = 1'b0;
        case (state_d)
            WLAT: begin
                hreadyout_d = 1'b0;
            end
            SETUP: begin
                hreadyout_d = 1'b0;
                psel_d      = NUM_SLAVES'(1) << slot_d;
            end
            ACCESS: begin
                hreadyout_d = 1'b0;
                psel_d      = NUM_SLAVES'(1) << slot_d;
                penable_d   = 1'b1;
            end
            ERR1: begin
                hreadyout_d = 1'b0;
                hresp_d     = HRESP_ERROR;
            end
            ERR2: begin
                hresp_d = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    // State, timeout counter and all bus-facing registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            tmo_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            psel_q      <= '0;
            penable_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            slot_q      <= slot_d;
            tmo_q       <= tmo_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule
